// File: rtl/mtimer_pkg.sv
// Shared constants for the multi-channel interval timer: register map and
// bit positions inside the STATUS and CONTROL words.
package mtimer_pkg;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD   = 3'd2;
    localparam logic [2:0] REG_PRESCALE = 3'd3;
    localparam logic [2:0] REG_SNAP     = 3'd4;
    localparam logic [2:0] REG_COUNT    = 3'd5;
    localparam logic [2:0] REG_RESERVED = 3'd6;
    localparam logic [2:0] REG_GLOBAL   = 3'd7;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    localparam int STAT_TO  = 0;
    localparam int STAT_RUN = 1;

endpackage

// File: rtl/multi_interval_timer_ch.sv
// One timer channel: configuration registers, prescaler, down-counter,
// zero-arrival edge detect and the sticky timeout flag.
module multi_interval_timer_ch
    import mtimer_pkg::*;
#(
    parameter int          CNT_W      = 32,
    parameter int          PRE_W      = 16,
    parameter logic [31:0] PERIOD_RST = 32'h0000C34F
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_control,
    input  logic             wr_period,
    input  logic             wr_prescale,
    input  logic             wr_snap,
    input  logic             status_clr,
    input  logic             start,
    input  logic             stop,
    input  logic [31:0]      wdata,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] snap,
    output logic [CNT_W-1:0] period,
    output logic [PRE_W-1:0] prescale,
    output logic             ito,
    output logic             cont,
    output logic             run,
    output logic             to,
    output logic             irq_ch
);

    localparam logic [CNT_W-1:0] PERIOD_INIT = PERIOD_RST[CNT_W-1:0];

    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] snap_reg;
    logic [PRE_W-1:0] prescale_reg;
    logic [PRE_W-1:0] pre_cnt_reg;
    logic             ito_reg;
    logic             cont_reg;
    logic             run_reg;
    logic             to_reg;
    logic             zero_d_reg;
    logic             force_reload_reg;

    logic count_zero;
    logic tick;
    logic timeout_event;

    assign count_zero    = (count_reg == '0);
    assign tick          = run_reg && (pre_cnt_reg == '0);
    assign timeout_event = count_zero && !zero_d_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_reg       <= PERIOD_INIT;
            count_reg        <= PERIOD_INIT;
            snap_reg         <= '0;
            prescale_reg     <= '0;
            pre_cnt_reg      <= '0;
            ito_reg          <= 1'b0;
            cont_reg         <= 1'b0;
            run_reg          <= 1'b0;
            to_reg           <= 1'b0;
            zero_d_reg       <= 1'b0;
            force_reload_reg <= 1'b0;
        end else begin
            if (wr_period)
                period_reg <= wdata[CNT_W-1:0];
            if (wr_prescale)
                prescale_reg <= wdata[PRE_W-1:0];
            if (wr_control) begin
                ito_reg  <= wdata[CTRL_ITO];
                cont_reg <= wdata[CTRL_CONT];
            end
            if (wr_snap)
                snap_reg <= count_reg;

            // A PERIOD write takes effect one edge later, like the legacy timer.
            force_reload_reg <= wr_period;

            if (!run_reg || start || tick)
                pre_cnt_reg <= prescale_reg;
            else
                pre_cnt_reg <= pre_cnt_reg - PRE_W'(1);

            if (force_reload_reg)
                count_reg <= period_reg;
            else if (tick) begin
                if (!count_zero)
                    count_reg <= count_reg - CNT_W'(1);
                else if (cont_reg)
                    count_reg <= period_reg;
            end

            if (start)
                run_reg <= 1'b1;
            else if (force_reload_reg || stop || (tick && count_zero && !cont_reg))
                run_reg <= 1'b0;

            zero_d_reg <= count_zero;

            // Setting beats clearing so a timeout coinciding with a clear is kept.
            if (timeout_event)
                to_reg <= 1'b1;
            else if (status_clr)
                to_reg <= 1'b0;
        end
    end

    assign count    = count_reg;
    assign snap     = snap_reg;
    assign period   = period_reg;
    assign prescale = prescale_reg;
    assign ito      = ito_reg;
    assign cont     = cont_reg;
    assign run      = run_reg;
    assign to       = to_reg;
    assign irq_ch   = to_reg & ito_reg;

endmodule

// File: rtl/multi_interval_timer.sv
// Avalon-MM slave wrapping NUM_CH independent interval timer channels,
// with a registered read mux and a single level interrupt.
module multi_interval_timer
    import mtimer_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          CNT_W      = 32,
    parameter logic [31:0] PERIOD_RST = 32'h0000C34F,
    parameter int          PRE_W      = 16,
    localparam int         ADDR_W     = 3 + $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam bit CH_FULL  = (NUM_CH == (1 << $clog2(NUM_CH)));

    logic [CH_W-1:0]   ch_sel;
    logic [2:0]        reg_sel;
    logic              ch_valid;
    logic              wr_en;
    logic              global_wr;
    logic [NUM_CH-1:0] to_vec;
    logic [NUM_CH-1:0] irq_vec;
    logic [31:0]       ch_rdata [NUM_CH];
    logic [31:0]       rd_mux;
    logic [31:0]       readdata_reg;

    assign reg_sel = address[2:0];

    generate
        if (NUM_CH > 1) begin : g_ch_field
            assign ch_sel = address[ADDR_W-1:3];
        end else begin : g_no_ch_field
            assign ch_sel = '0;
        end

        // Only a non-power-of-two channel count leaves unused channel codes.
        if (CH_FULL) begin : g_all_valid
            assign ch_valid = 1'b1;
        end else begin : g_range_check
            assign ch_valid = (ch_sel < CH_W'(NUM_CH));
        end
    endgenerate

    assign wr_en     = chipselect && !write_n && ch_valid;
    assign global_wr = wr_en && (reg_sel == REG_GLOBAL);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic             hit;
            logic             wr_ctrl;
            logic [CNT_W-1:0] count;
            logic [CNT_W-1:0] snap;
            logic [CNT_W-1:0] period;
            logic [PRE_W-1:0] prescale;
            logic             ito;
            logic             cont;
            logic             run;
            logic [31:0]      rd;

            assign hit     = wr_en && (ch_sel == CH_W'(gi));
            assign wr_ctrl = hit && (reg_sel == REG_CONTROL);

            multi_interval_timer_ch #(
                .CNT_W      (CNT_W),
                .PRE_W      (PRE_W),
                .PERIOD_RST (PERIOD_RST)
            ) u_ch (
                .clk         (clk),
                .reset       (reset),
                .wr_control  (wr_ctrl),
                .wr_period   (hit && (reg_sel == REG_PERIOD)),
                .wr_prescale (hit && (reg_sel == REG_PRESCALE)),
                .wr_snap     (hit && (reg_sel == REG_SNAP)),
                .status_clr  (hit && (reg_sel == REG_STATUS)),
                .start       ((wr_ctrl && writedata[CTRL_START]) || (global_wr && writedata[gi])),
                .stop        (wr_ctrl && writedata[CTRL_STOP]),
                .wdata       (writedata),
                .count       (count),
                .snap        (snap),
                .period      (period),
                .prescale    (prescale),
                .ito         (ito),
                .cont        (cont),
                .run         (run),
                .to          (to_vec[gi]),
                .irq_ch      (irq_vec[gi])
            );

            always_comb begin
                rd = '0;
                case (reg_sel)
                    REG_STATUS: begin
                        rd[STAT_TO]  = to_vec[gi];
                        rd[STAT_RUN] = run;
                    end
                    REG_CONTROL: begin
                        rd[CTRL_ITO]  = ito;
                        rd[CTRL_CONT] = cont;
                    end
                    REG_PERIOD:   rd = 32'(period);
                    REG_PRESCALE: rd = 32'(prescale);
                    REG_SNAP:     rd = 32'(snap);
                    REG_COUNT:    rd = 32'(count);
                    REG_GLOBAL:   rd = 32'(to_vec);
                    default:      rd = '0;
                endcase
            end

            assign ch_rdata[gi] = rd;
        end
    endgenerate

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_valid && (ch_sel == CH_W'(i)))
                rd_mux = ch_rdata[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            readdata_reg <= '0;
        else
            readdata_reg <= rd_mux;
    end

    assign readdata = readdata_reg;
    assign irq      = |irq_vec;

endmodule
